// File: rtl/pipelined_merge_accumulator.sv
// pipelined_merge_accumulator
//
// Purpose:
//    Registered, handshaked merge stage for the conv datapath. Each accepted
//    beat carries NUM_INPUTS signed elements that are summed by a binary adder
//    tree with one register per tree level. Tree sums are then accumulated
//    across a first..last group of beats, and one merged result is emitted
//    per group.
//
// Ports:
//    clk        in   clock, all state updates on the rising edge
//    rst        in   synchronous active-high reset
//    in_valid   in   input beat valid
//    in_ready   out  block can accept a beat this cycle
//    in_first   in   beat opens a new accumulation group
//    in_last    in   beat closes the group (first & last = one-beat group)
//    in_data    in   element i at [i*IN_WIDTH +: IN_WIDTH]
//    out_valid  out  merged result valid
//    out_ready  in   downstream accepts the result
//    out_data   out  merged signed result
//    out_sat    out  result was clamped (tied 0 unless MERGE_SATURATE_EN)
//
// Build option:
//    MERGE_SATURATE_EN  when defined, each accumulate step clamps to the
//                       signed OUT_WIDTH range and a sticky per-group flag
//                       is reported on out_sat. When undefined, the
//                       accumulator wraps in two's complement.

module pipelined_merge_accumulator #(
    parameter int NUM_INPUTS = 18,
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_first,
    input  logic                             in_last,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0]   in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_sat
);

    // Tree depth, padded leaf count and the exact width of a tree sum.
    localparam int DEPTH  = $clog2(NUM_INPUTS);
    localparam int PADDED = 1 << DEPTH;
    localparam int SUM_W  = IN_WIDTH + DEPTH;

    // One global advance enable: the whole pipeline moves only when the
    // output register is empty or being drained this cycle.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Tree output as seen by the accumulator stage.
    logic                    tree_valid;
    logic                    tree_first;
    logic                    tree_last;
    logic signed [SUM_W-1:0] tree_sum;

    generate
        if (DEPTH == 0) begin : g_pass
            // A single element needs no tree; it feeds the accumulator directly.
            assign tree_valid = in_valid;
            assign tree_first = in_first;
            assign tree_last  = in_last;
            assign tree_sum   = $signed(in_data[IN_WIDTH-1:0]);
        end else begin : g_tree
            // Heap-indexed tree: node n has children 2n and 2n+1, the root is
            // node 1, and indices PADDED..2*PADDED-1 are the (combinational)
            // leaves. Every node is registered, so the root sits DEPTH
            // registers after the leaves along every path.
            logic signed [SUM_W-1:0] leaf      [PADDED];
            logic signed [SUM_W-1:0] node      [1:PADDED-1];
            logic signed [SUM_W-1:0] node_next [1:PADDED-1];
            logic [DEPTH-1:0]        vld;
            logic [DEPTH-1:0]        fst;
            logic [DEPTH-1:0]        lst;

            for (genvar i = 0; i < PADDED; i++) begin : g_leaf
                if (i < NUM_INPUTS) begin : g_elem
                    assign leaf[i] = SUM_W'($signed(in_data[i*IN_WIDTH +: IN_WIDTH]));
                end else begin : g_zero
                    assign leaf[i] = '0;
                end
            end

            for (genvar n = 1; n < PADDED; n++) begin : g_node
                if (2*n >= PADDED) begin : g_bottom
                    assign node_next[n] = leaf[2*n-PADDED] + leaf[2*n+1-PADDED];
                end else begin : g_inner
                    assign node_next[n] = node[2*n] + node[2*n+1];
                end
            end

            // Tree registers and the valid/first/last tags that travel with
            // each beat; everything holds while the output is stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= '0;
                    fst <= '0;
                    lst <= '0;
                    for (int n = 1; n < PADDED; n++) begin
                        node[n] <= '0;
                    end
                end else if (adv) begin
                    node   <= node_next;
                    vld[0] <= in_valid;
                    fst[0] <= in_first;
                    lst[0] <= in_last;
                    for (int k = 1; k < DEPTH; k++) begin
                        vld[k] <= vld[k-1];
                        fst[k] <= fst[k-1];
                        lst[k] <= lst[k-1];
                    end
                end
            end

            assign tree_valid = vld[DEPTH-1];
            assign tree_first = fst[DEPTH-1];
            assign tree_last  = lst[DEPTH-1];
            assign tree_sum   = node[1];
        end
    endgenerate

    // Accumulator state. A beat starts a fresh group when it is marked first
    // or when no group is open (a stray non-first beat acts as first).
    logic                        acc_open;
    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] acc_base;
    logic signed [OUT_WIDTH-1:0] acc_next;
    logic                        group_start;

    assign group_start = tree_first || !acc_open;
    assign acc_base    = group_start ? '0 : acc;

`ifdef MERGE_SATURATE_EN
    localparam logic signed [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [OUT_WIDTH:0] acc_wide;
    logic                      clip;
    logic                      sat_sticky;
    logic                      group_sat;
    logic                      sat_q;

    // One guard bit: the top two bits disagree exactly when the sum left
    // the OUT_WIDTH range, and the guard bit gives the direction.
    assign acc_wide  = (OUT_WIDTH+1)'(acc_base) + (OUT_WIDTH+1)'(tree_sum);
    assign clip      = acc_wide[OUT_WIDTH] != acc_wide[OUT_WIDTH-1];
    assign acc_next  = clip ? (acc_wide[OUT_WIDTH] ? ACC_MIN : ACC_MAX)
                            : acc_wide[OUT_WIDTH-1:0];
    assign group_sat = (!group_start && sat_sticky) || clip;
    assign out_sat   = sat_q;
`else
    // Dropping the guard bit is the same as summing at OUT_WIDTH bits, so
    // the wrap falls out of plain OUT_WIDTH arithmetic.
    assign acc_next = acc_base + OUT_WIDTH'(tree_sum);
    assign out_sat  = 1'b0;
`endif

    // Accumulate stage and output register. Under advance the output is
    // either empty or being consumed, so it clears unless a group closes
    // this same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            acc_open  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef MERGE_SATURATE_EN
            sat_sticky <= 1'b0;
            sat_q      <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= 1'b0;
            if (tree_valid) begin
                acc      <= acc_next;
                acc_open <= !tree_last;
`ifdef MERGE_SATURATE_EN
                sat_sticky <= group_sat;
`endif
                if (tree_last) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_next;
`ifdef MERGE_SATURATE_EN
                    sat_q <= group_sat;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_merge_accumulator.sv
// tb_pipelined_merge_accumulator
//
// Purpose:
//    Directed and randomized bench for pipelined_merge_accumulator
//    (NUM_INPUTS=18, IN_WIDTH=8, OUT_WIDTH=16). A group-level reference
//    model tracks accepted beats with plain integer arithmetic and queues
//    the expected result of each group; a monitor compares every output
//    handshake against that queue.

module tb_pipelined_merge_accumulator;

    localparam int NI  = 18;
    localparam int IW  = 8;
    localparam int OW  = 16;
    localparam int LAT = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_first;
    logic                 in_last;
    logic [NI*IW-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;

    pipelined_merge_accumulator #(
        .NUM_INPUTS (NI),
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     sat;
    } result_t;

    int      checks = 0;
    int      passes = 0;
    int      fails  = 0;
    result_t exp_q[$];
    longint  got_q[$];
    result_t r_cur;
    longint  m_acc;
    longint  beat_sum;
    bit      m_open;
    bit      m_sat;
    bit      saw_stall;
    int      stall_left;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Two's-complement wrap of an arbitrary integer into OW bits.
    function automatic longint wrapOut(input longint x);
        longint m;
        m = longint'(1) << OW;
        return (((x + m/2) % m) + m) % m - m/2;
    endfunction

    function automatic logic [NI*IW-1:0] fillAll(input int v);
        logic [NI*IW-1:0] d;
        for (int i = 0; i < NI; i++) d[i*IW +: IW] = IW'(v);
        return d;
    endfunction

    function automatic logic [NI*IW-1:0] fillRandom();
        logic [NI*IW-1:0] d;
        for (int i = 0; i < NI; i++) d[i*IW +: IW] = IW'($urandom);
        return d;
    endfunction

    // Reference model and output monitor, evaluated mid-cycle when all
    // handshake signals are stable.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_open = 1'b0;
            m_acc  = 0;
            m_sat  = 1'b0;
        end else begin
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && exp_q.size() == 0) begin
                checkOutput("spurious_out_valid", 1, 0);
            end else if (out_valid && out_ready) begin
                r_cur = exp_q.pop_front();
                checkOutput("out_data", out_data, r_cur.data);
                checkOutput("out_sat", out_sat, r_cur.sat);
                got_q.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                beat_sum = 0;
                for (int i = 0; i < NI; i++) beat_sum += longint'($signed(in_data[i*IW +: IW]));
                if (in_first || !m_open) begin
                    m_acc = 0;
                    m_sat = 1'b0;
                end
                m_acc = m_acc + beat_sum;
`ifdef MERGE_SATURATE_EN
                if (m_acc > 32767) begin
                    m_acc = 32767;
                    m_sat = 1'b1;
                end else if (m_acc < -32768) begin
                    m_acc = -32768;
                    m_sat = 1'b1;
                end
`else
                m_acc = wrapOut(m_acc);
`endif
                m_open = !in_last;
                if (in_last) begin
                    r_cur.data = m_acc;
                    r_cur.sat  = m_sat;
                    exp_q.push_back(r_cur);
                end
            end
        end
    end

    // Offer one beat and hold it until accepted. Called just after a rising
    // edge; returns just after the edge that accepted the beat.
    task automatic applyStimulus(input bit f, input bit l, input logic [NI*IW-1:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 60) begin
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
            else out_ready = 1'b1;
            @(negedge clk);
            waited++;
        end
        if (waited >= 60) checkOutput("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitOutputs(input string tag, input int target);
        int w;
        w = 0;
        while (got_q.size() < target && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        idleCycles(8);
        checkOutput(tag, got_q.size(), target);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int cnt;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        stall_left = 0;
        saw_stall  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_sat", out_sat, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Test 1: single-beat group of ones, latency from acceptance.
        base = got_q.size();
        applyStimulus(1'b1, 1'b1, fillAll(1));
        cnt = 1;
        @(negedge clk);
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t1_latency", cnt, LAT);
        waitOutputs("t1_count", base + 1);
        checkOutput("t1_value", got_q[base], 18);

        // Test 2: three beats of -128 make one result.
        base = got_q.size();
        applyStimulus(1'b1, 1'b0, fillAll(-128));
        applyStimulus(1'b0, 1'b0, fillAll(-128));
        applyStimulus(1'b0, 1'b1, fillAll(-128));
        waitOutputs("t2_count", base + 1);
        checkOutput("t2_value", got_q[base], -6912);

        // Test 3: twenty beats of 127 overflow the accumulator.
        base = got_q.size();
        for (int b = 0; b < 20; b++) applyStimulus(b == 0, b == 19, fillAll(127));
        waitOutputs("t3_count", base + 1);
`ifdef MERGE_SATURATE_EN
        checkOutput("t3_value", got_q[base], 32767);
        checkOutput("t3_sat", out_sat, 1);
`else
        checkOutput("t3_value", got_q[base], -19816);
        checkOutput("t3_sat", out_sat, 0);
`endif

        // Test 4: back-to-back single-beat groups with a downstream stall.
        base       = got_q.size();
        saw_stall  = 1'b0;
        out_ready  = 1'b0;
        stall_left = 10;
        for (int v = 1; v <= 10; v++) applyStimulus(1'b1, 1'b1, fillAll(v));
        out_ready = 1'b1;
        waitOutputs("t4_count", base + 10);
        checkOutput("t4_in_ready_dropped", saw_stall, 1);
        for (int v = 1; v <= 10; v++) checkOutput("t4_order", got_q[base+v-1], 18*v);

        // Test 5: reset in the middle of an open group.
        base = got_q.size();
        applyStimulus(1'b1, 1'b0, fillAll(1));
        applyStimulus(1'b0, 1'b0, fillAll(1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_valid_in_reset", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t5_valid_after_reset", out_valid, 0);
        applyStimulus(1'b1, 1'b1, fillAll(2));
        waitOutputs("t5_count", base + 1);
        checkOutput("t5_value", got_q[base], 36);

        // Test 6: a new first beat discards the open partial.
        base = got_q.size();
        applyStimulus(1'b1, 1'b0, fillAll(5));
        applyStimulus(1'b1, 1'b1, fillAll(1));
        waitOutputs("t6_count", base + 1);
        checkOutput("t6_value", got_q[base], 18);

        // Randomized groups, data and backpressure.
        for (int b = 0; b < 250; b++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, fillRandom());
            if ($urandom_range(0, 4) == 0) idleCycles(1);
        end
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, fillRandom());
        idleCycles(30);
        checkOutput("pending_results", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
